// File: rtl/lte_ul_tdl_agc.sv
// Uplink block-floating AGC: per-antenna windowed peak tracking and a
// shift table that normalises 32-bit IQ samples to 30-bit IQ.
module lte_ul_tdl_agc #(
    parameter int WIN_LOG2 = 10,
    parameter int HEADROOM = 1
) (
    input  logic        clk_245,
    input  logic        syn_rst,
    input  logic        i_fram_hd,
    input  logic [31:0] i_data,
    input  logic        i_data_valid,
    input  logic        i_ant8_sel,
    input  logic        i_agc_en,
    output logic        o_fram_hd,
    output logic        o_ant8_sel,
    output logic        o_data_valid,
    output logic [29:0] o_data,
    output logic [2:0]  o_ant_idx,
    output logic [2:0]  o_shift,
    output logic        o_agc_upd
);

    localparam int RW = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
    localparam logic [RW-1:0] RND_LAST = RW'((64'd1 << WIN_LOG2) - 64'd1);
    localparam logic [22:0] PK_LIMIT = 23'(64'd1 << (15 - HEADROOM));

    function automatic logic [14:0] abs_sat(input logic [15:0] x);
        logic [15:0] n;
        n = x[15] ? (~x + 16'd1) : x;
        return n[15] ? 15'h7FFF : n[14:0];
    endfunction

    function automatic logic [2:0] calc_shift(input logic [14:0] pk);
        logic [2:0] s;
        s = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (({8'd0, pk} << k) < PK_LIMIT) begin
                s = 3'(k);
            end
        end
        return s;
    endfunction

    function automatic logic [14:0] sat15(input logic [22:0] v);
        logic [14:0] r;
        r = v[14:0];
        if (!v[22] && (v[21:14] != 8'h00)) begin
            r = 15'h3FFF;
        end else if (v[22] && (v[21:14] != 8'hFF)) begin
            r = 15'h4000;
        end
        return r;
    endfunction

    logic [2:0]    ant_cnt_q, ant_cnt_d;
    logic [RW-1:0] round_q, round_d;
    logic          win_end_q, win_end_d;
    logic [14:0]   peak_q [8];
    logic [14:0]   peak_d [8];
    logic [2:0]    shift_q [8];
    logic [2:0]    shift_d [8];

    logic [2:0]    cur_idx;
    logic [2:0]    last_idx;
    logic [14:0]   mag_i, mag_q, mag;
    logic          fh_acc;
    logic          tbl_upd;

    logic          s1_vld_q, s1_vld_d;
    logic          s1_fh_q, s1_fh_d;
    logic          s1_a8_q, s1_a8_d;
    logic [2:0]    s1_idx_q, s1_idx_d;
    logic [2:0]    s1_sh_q, s1_sh_d;
    logic [15:0]   s1_i_q, s1_i_d;
    logic [15:0]   s1_q_q, s1_q_d;

    logic          s2_vld_q, s2_vld_d;
    logic          s2_fh_q, s2_fh_d;
    logic          s2_a8_q, s2_a8_d;
    logic [2:0]    s2_idx_q, s2_idx_d;
    logic [2:0]    s2_sh_q, s2_sh_d;
    logic [22:0]   s2_i_q, s2_i_d;
    logic [22:0]   s2_q_q, s2_q_d;

    logic          o_vld_q, o_vld_d;
    logic          o_fh_q, o_fh_d;
    logic          o_a8_q, o_a8_d;
    logic [2:0]    o_idx_q, o_idx_d;
    logic [2:0]    o_sh_q, o_sh_d;
    logic [29:0]   o_data_q, o_data_d;

    logic signed [22:0] xi, xq;

    assign mag_i = abs_sat(i_data[31:16]);
    assign mag_q = abs_sat(i_data[15:0]);
    assign mag   = (mag_i > mag_q) ? mag_i : mag_q;

    // Antenna/round counting, peak tracking and window-end table rewrite
    always_comb begin
        ant_cnt_d = ant_cnt_q;
        round_d   = round_q;
        win_end_d = 1'b0;
        peak_d    = peak_q;
        shift_d   = shift_q;
        fh_acc    = i_data_valid && i_fram_hd;
        tbl_upd   = win_end_q && !fh_acc;
        cur_idx   = i_fram_hd ? 3'd0 : ant_cnt_q;
        last_idx  = i_ant8_sel ? 3'd7 : 3'd3;
        if (tbl_upd) begin
            for (int a = 0; a < 8; a++) begin
                shift_d[a] = calc_shift(peak_q[a]);
                peak_d[a]  = '0;
            end
            round_d = '0;
        end
        if (i_data_valid) begin
            if (i_fram_hd) begin
                for (int a = 0; a < 8; a++) begin
                    peak_d[a] = '0;
                end
                round_d = '0;
            end
            if (mag > peak_d[cur_idx]) begin
                peak_d[cur_idx] = mag;
            end
            if (cur_idx >= last_idx) begin
                ant_cnt_d = 3'd0;
                if (round_d == RND_LAST) begin
                    round_d   = '0;
                    win_end_d = 1'b1;
                end else begin
                    round_d = round_d + 1'b1;
                end
            end else begin
                ant_cnt_d = cur_idx + 3'd1;
            end
        end
    end

    // Three-stage datapath: capture + lookup, barrel shift, saturate
    always_comb begin
        s1_vld_d = i_data_valid;
        s1_fh_d  = i_fram_hd;
        s1_a8_d  = i_ant8_sel;
        s1_idx_d = cur_idx;
        s1_sh_d  = i_agc_en ? shift_q[cur_idx] : 3'd0;
        s1_i_d   = i_data[31:16];
        s1_q_d   = i_data[15:0];

        xi = $signed({{7{s1_i_q[15]}}, s1_i_q}) <<< s1_sh_q;
        xq = $signed({{7{s1_q_q[15]}}, s1_q_q}) <<< s1_sh_q;
        s2_vld_d = s1_vld_q;
        s2_fh_d  = s1_fh_q;
        s2_a8_d  = s1_a8_q;
        s2_idx_d = s1_idx_q;
        s2_sh_d  = s1_sh_q;
        s2_i_d   = xi >>> 1;
        s2_q_d   = xq >>> 1;

        o_vld_d  = s2_vld_q;
        o_fh_d   = s2_fh_q;
        o_a8_d   = s2_a8_q;
        o_idx_d  = s2_idx_q;
        o_sh_d   = s2_sh_q;
        o_data_d = o_data_q;
        if (s2_vld_q) begin
            o_data_d = {sat15(s2_i_q), sat15(s2_q_q)};
        end
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk_245) begin
        if (syn_rst) begin
            ant_cnt_q <= '0;
            round_q   <= '0;
            win_end_q <= 1'b0;
            for (int a = 0; a < 8; a++) begin
                peak_q[a]  <= '0;
                shift_q[a] <= '0;
            end
            s1_vld_q <= 1'b0;
            s1_fh_q  <= 1'b0;
            s1_a8_q  <= 1'b0;
            s1_idx_q <= '0;
            s1_sh_q  <= '0;
            s1_i_q   <= '0;
            s1_q_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_fh_q  <= 1'b0;
            s2_a8_q  <= 1'b0;
            s2_idx_q <= '0;
            s2_sh_q  <= '0;
            s2_i_q   <= '0;
            s2_q_q   <= '0;
            o_vld_q  <= 1'b0;
            o_fh_q   <= 1'b0;
            o_a8_q   <= 1'b0;
            o_idx_q  <= '0;
            o_sh_q   <= '0;
            o_data_q <= '0;
        end else begin
            ant_cnt_q <= ant_cnt_d;
            round_q   <= round_d;
            win_end_q <= win_end_d;
            peak_q    <= peak_d;
            shift_q   <= shift_d;
            s1_vld_q  <= s1_vld_d;
            s1_fh_q   <= s1_fh_d;
            s1_a8_q   <= s1_a8_d;
            s1_idx_q  <= s1_idx_d;
            s1_sh_q   <= s1_sh_d;
            s1_i_q    <= s1_i_d;
            s1_q_q    <= s1_q_d;
            s2_vld_q  <= s2_vld_d;
            s2_fh_q   <= s2_fh_d;
            s2_a8_q   <= s2_a8_d;
            s2_idx_q  <= s2_idx_d;
            s2_sh_q   <= s2_sh_d;
            s2_i_q    <= s2_i_d;
            s2_q_q    <= s2_q_d;
            o_vld_q   <= o_vld_d;
            o_fh_q    <= o_fh_d;
            o_a8_q    <= o_a8_d;
            o_idx_q   <= o_idx_d;
            o_sh_q    <= o_sh_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_data_valid = o_vld_q;
    assign o_fram_hd    = o_fh_q;
    assign o_ant8_sel   = o_a8_q;
    assign o_ant_idx    = o_idx_q;
    assign o_shift      = o_sh_q;
    assign o_data       = o_data_q;
    assign o_agc_upd    = tbl_upd && !syn_rst;

endmodule

// File: tb/tb_lte_ul_tdl_agc.sv
// Bench for lte_ul_tdl_agc: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_lte_ul_tdl_agc;

    localparam int WL = 2;
    localparam int HR = 1;

    logic        clk = 1'b0;
    logic        syn_rst;
    logic        i_fram_hd;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        i_ant8_sel;
    logic        i_agc_en;
    logic        o_fram_hd;
    logic        o_ant8_sel;
    logic        o_data_valid;
    logic [29:0] o_data;
    logic [2:0]  o_ant_idx;
    logic [2:0]  o_shift;
    logic        o_agc_upd;

    always #5 clk = ~clk;

    lte_ul_tdl_agc #(.WIN_LOG2(WL), .HEADROOM(HR)) dut (
        .clk_245      (clk),
        .syn_rst      (syn_rst),
        .i_fram_hd    (i_fram_hd),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_ant8_sel   (i_ant8_sel),
        .i_agc_en     (i_agc_en),
        .o_fram_hd    (o_fram_hd),
        .o_ant8_sel   (o_ant8_sel),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_ant_idx    (o_ant_idx),
        .o_shift      (o_shift),
        .o_agc_upd    (o_agc_upd)
    );

    int n_tot   = 0;
    int n_pass  = 0;
    int upd_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        v;
        logic        fh;
        logic        a8;
        logic [2:0]  idx;
        logic [2:0]  s;
        logic [29:0] d;
    } rec_t;

    rec_t        rq[$];
    int          m_peak[8];
    int          m_shift[8];
    int          m_cnt;
    int          m_round;
    bit          m_pend;
    logic [29:0] m_hold;

    function automatic int mag16(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic int shift_for(input int pk);
        int r;
        r = 0;
        for (int s = 0; s < 8; s++) begin
            if (pk * (1 << s) < (1 << (15 - HR))) r = s;
        end
        return r;
    endfunction

    function automatic logic [14:0] scale(input logic [15:0] x, input int s);
        int v;
        v = int'($signed(x)) * (1 << s);
        v = v >>> 1;
        if (v > 16383) v = 16383;
        if (v < -16384) v = -16384;
        return 15'(v);
    endfunction

    task automatic model_step();
        rec_t r;
        int   sold[8];
        int   idx;
        int   last;
        int   mg;
        r = '0;
        if (syn_rst) begin
            for (int a = 0; a < 8; a++) begin
                m_peak[a]  = 0;
                m_shift[a] = 0;
            end
            m_cnt   = 0;
            m_round = 0;
            m_pend  = 0;
            m_hold  = '0;
            rq.delete();
            repeat (3) rq.push_back(r);
        end else begin
            r.v  = i_data_valid;
            r.fh = i_fram_hd;
            r.a8 = i_ant8_sel;
            sold = m_shift;
            if (m_pend && !(i_data_valid && i_fram_hd)) begin
                for (int a = 0; a < 8; a++) begin
                    m_shift[a] = shift_for(m_peak[a]);
                    m_peak[a]  = 0;
                end
                m_round = 0;
            end
            m_pend = 0;
            if (i_data_valid) begin
                idx = i_fram_hd ? 0 : m_cnt;
                if (i_fram_hd) begin
                    for (int a = 0; a < 8; a++) m_peak[a] = 0;
                    m_round = 0;
                end
                mg = mag16(i_data[31:16]);
                if (mag16(i_data[15:0]) > mg) mg = mag16(i_data[15:0]);
                if (mg > m_peak[idx]) m_peak[idx] = mg;
                last = i_ant8_sel ? 7 : 3;
                if (idx >= last) begin
                    m_cnt = 0;
                    if (m_round == (1 << WL) - 1) begin
                        m_round = 0;
                        m_pend  = 1;
                    end else begin
                        m_round++;
                    end
                end else begin
                    m_cnt = idx + 1;
                end
                r.idx  = 3'(idx);
                r.s    = i_agc_en ? 3'(sold[idx]) : 3'd0;
                m_hold = {scale(i_data[31:16], int'(r.s)), scale(i_data[15:0], int'(r.s))};
            end
            r.d = m_hold;
            rq.push_back(r);
            if (rq.size() > 3) void'(rq.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // per-cycle comparison against the model
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rq.size() == 3) begin
                e = rq[0];
                chk("valid", 32'(o_data_valid), 32'(e.v));
                chk("data", 32'(o_data), 32'(e.d));
                if (e.v) begin
                    chk("ant_idx", 32'(o_ant_idx), 32'(e.idx));
                    chk("shift", 32'(o_shift), 32'(e.s));
                    chk("fram_hd", 32'(o_fram_hd), 32'(e.fh));
                    chk("ant8_sel", 32'(o_ant8_sel), 32'(e.a8));
                end
                chk("agc_upd", 32'(o_agc_upd),
                    32'(m_pend && !syn_rst && !(i_data_valid && i_fram_hd)));
                if (o_agc_upd) upd_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] rnd16();
        logic [15:0] v;
        if ($urandom_range(0, 31) == 0) return 16'h8000;
        v = 16'($urandom);
        return 16'($signed(v) >>> $urandom_range(0, 15));
    endfunction

    function automatic logic [31:0] rnd32();
        return {rnd16(), rnd16()};
    endfunction

    task automatic drive(input logic fh, input logic [31:0] d, input logic a8, input logic en);
        i_fram_hd    = fh;
        i_data       = d;
        i_data_valid = 1'b1;
        i_ant8_sel   = a8;
        i_agc_en     = en;
        @(negedge clk);
    endtask

    task automatic idle();
        i_fram_hd    = 1'b0;
        i_data_valid = 1'b0;
        @(negedge clk);
    endtask

    localparam logic [31:0] C100 = 32'h0100_0000;

    initial begin
        logic [31:0] d;
        int          base;
        logic        a8;
        logic        v;
        logic        fh;

        syn_rst      = 1'b1;
        i_fram_hd    = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_ant8_sel   = 1'b1;
        i_agc_en     = 1'b1;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            i_data       = $urandom;
            i_fram_hd    = 1'($urandom);
            i_data_valid = 1'($urandom);
            i_ant8_sel   = 1'($urandom);
            i_agc_en     = 1'($urandom);
            @(negedge clk);
            #1;
            chk("rst_data", 32'(o_data), 32'd0);
            chk("rst_ctl", 32'({o_ant_idx, o_shift, o_fram_hd, o_ant8_sel,
                                o_data_valid, o_agc_upd}), 32'd0);
        end
        syn_rst = 1'b0;
        i_ant8_sel = 1'b1;
        i_agc_en = 1'b1;
        idle();
        idle();

        // first-sample latency
        drive(1'b1, rnd32(), 1'b1, 1'b1);
        idle();
        #1 chk("lat_not_yet", 32'(o_data_valid), 32'd0);
        idle();
        #1 chk("lat_3cyc", 32'(o_data_valid), 32'd1);
        idle();

        // constant window, 8 antennas
        base = upd_cnt;
        for (int i = 0; i < 32; i++) begin
            drive(i == 0, C100, 1'b1, 1'b1);
            if (i == 3) begin
                #1;
                chk("win1_data", 32'(o_data), 32'({15'h0080, 15'h0000}));
                chk("win1_shift", 32'(o_shift), 32'd0);
                chk("win1_idx", 32'(o_ant_idx), 32'd1);
            end
            if (i == 30) chk("win1_no_early_upd", 32'(upd_cnt - base), 32'd0);
        end
        #1 chk("win1_upd", 32'(o_agc_upd), 32'd1);
        idle();
        #1 chk("win1_upd_pulse", 32'(o_agc_upd), 32'd0);
        chk("win1_upd_once", 32'(upd_cnt - base), 32'd1);
        drive(1'b0, C100, 1'b1, 1'b1);
        idle();
        idle();
        #1;
        chk("win2_shift", 32'(o_shift), 32'd5);
        chk("win2_data", 32'(o_data), 32'({15'h1000, 15'h0000}));
        chk("win2_idx", 32'(o_ant_idx), 32'd0);

        // saturation with shift 5
        drive(1'b0, 32'h4000_C000, 1'b1, 1'b1);
        idle();
        idle();
        #1;
        chk("sat_data", 32'(o_data), 32'({15'h3FFF, 15'h4000}));
        chk("sat_shift", 32'(o_shift), 32'd5);
        idle();
        idle();
        idle();

        // 4-antenna mode
        base = upd_cnt;
        for (int i = 0; i < 16; i++) begin
            drive(i == 0, rnd32(), 1'b0, 1'b1);
            if (i >= 2 && i <= 6) begin
                #1 chk("ant4_idx", 32'(o_ant_idx), 32'((i - 2) % 4));
            end
            if (i == 14) chk("ant4_no_early_upd", 32'(upd_cnt - base), 32'd0);
        end
        #1 chk("ant4_upd", 32'(o_agc_upd), 32'd1);
        idle();
        idle();
        idle();

        // frame head mid-window
        base = upd_cnt;
        for (int i = 0; i < 19; i++) drive(i == 0, rnd32(), 1'b1, 1'b1);
        for (int j = 0; j < 32; j++) begin
            drive(j == 0, rnd32(), 1'b1, 1'b1);
            if (j == 2) begin
                #1;
                chk("fh_idx", 32'(o_ant_idx), 32'd0);
                chk("fh_out", 32'(o_fram_hd), 32'd1);
            end
            if (j == 30) chk("fh_no_early_upd", 32'(upd_cnt - base), 32'd0);
        end
        #1 chk("fh_upd", 32'(o_agc_upd), 32'd1);
        idle();
        idle();
        idle();

        // zero window then AGC disable
        for (int i = 0; i < 32; i++) drive(i == 0, 32'd0, 1'b1, 1'b1);
        #1 chk("zero_upd", 32'(o_agc_upd), 32'd1);
        idle();
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        idle();
        idle();
        #1;
        chk("zero_shift", 32'(o_shift), 32'd7);
        chk("zero_data", 32'(o_data), 32'd0);
        d = rnd32();
        drive(1'b0, d, 1'b1, 1'b0);
        idle();
        idle();
        #1;
        chk("dis_shift", 32'(o_shift), 32'd0);
        chk("dis_data", 32'(o_data), 32'({d[31:17], d[15:1]}));
        idle();

        // randomized traffic with a mid-run reset
        a8 = 1'b1;
        i_agc_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            syn_rst = (n >= 700 && n < 703);
            v  = ($urandom_range(0, 9) != 0);
            fh = ($urandom_range(0, 63) == 0);
            if (v && fh && $urandom_range(0, 1) == 1) a8 = ~a8;
            i_data_valid = v;
            i_fram_hd    = fh;
            i_data       = rnd32();
            i_ant8_sel   = a8;
            if ($urandom_range(0, 99) == 0) i_agc_en = ~i_agc_en;
            @(negedge clk);
        end
        syn_rst = 1'b0;
        repeat (5) idle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
